// File: rtl/wfifo_pkg.sv
// Shared helpers for the async FIFO pointer blocks: Gray/binary conversion
// on a fixed maximum width (callers zero-extend and slice) and common widths.
package wfifo_pkg;

  localparam int DROP_CNT_W = 16;
  localparam int GRAY_MAX_W = 32;

  // Prefix XOR from the MSB down; zero-extended upper bits do not disturb the result.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = g;
    for (int s = 1; s < GRAY_MAX_W; s = s * 2)
      b = b ^ (b >> s);
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return (b >> 1) ^ b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter of configurable width.
module gray2bin_conv
  import wfifo_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin = W'(gray2bin(GRAY_MAX_W'(gray)));

endmodule

// File: rtl/wptr_full_level.sv
// Write-domain pointer/status for the async FIFO: address, Gray pointer, full,
// level, almost-full, sticky overflow. Drop counter built only with WPTR_FULL_DROP_CNT_EN.
module wptr_full_level
  import wfifo_pkg::*;
#(
  parameter int ADDRSIZE = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  winc,
  input  logic [ADDRSIZE:0]     wq2_rptr,
  input  logic [ADDRSIZE:0]     afull_thresh,
  input  logic                  wovf_clr,
  output logic [ADDRSIZE-1:0]   waddr,
  output logic [ADDRSIZE:0]     wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDRSIZE:0]     wlevel,
  output logic                  woverflow,
  output logic [DROP_CNT_W-1:0] wdrop_cnt
);

  localparam int LEVEL_W = ADDRSIZE + 1;

  logic [ADDRSIZE:0]  wbin;
  logic [ADDRSIZE:0]  wbinnext;
  logic [ADDRSIZE:0]  wgraynext;
  logic [ADDRSIZE:0]  rbin_s;
  logic [LEVEL_W-1:0] wlevel_next;
  logic               wen;
  logic               wdrop;
  logic               wfull_next;

  gray2bin_conv #(.W(ADDRSIZE + 1)) u_rptr_conv (
    .gray (wq2_rptr),
    .bin  (rbin_s)
  );

  // Gating with the registered wfull means a write in the cycle the read side frees space is still dropped.
  assign wen         = winc & ~wfull;
  assign wdrop       = winc & wfull;
  assign wbinnext    = wbin + {{ADDRSIZE{1'b0}}, wen};
  assign wgraynext   = (ADDRSIZE+1)'(bin2gray(GRAY_MAX_W'(wbinnext)));
  assign wfull_next  = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
  assign wlevel_next = wbinnext - rbin_s;
  assign waddr       = wbin[ADDRSIZE-1:0];

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      wlevel       <= '0;
      walmost_full <= 1'b0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= wfull_next;
      wlevel       <= wlevel_next;
      walmost_full <= (wlevel_next >= afull_thresh);
      woverflow    <= wdrop | (woverflow & ~wovf_clr);
    end
  end

`ifdef WPTR_FULL_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n)
      drop_cnt_q <= '0;
    else if (wovf_clr)
      drop_cnt_q <= {{(DROP_CNT_W-1){1'b0}}, wdrop};
    else if (wdrop && (drop_cnt_q != {DROP_CNT_W{1'b1}}))
      drop_cnt_q <= drop_cnt_q + 1'b1;
  end

  assign wdrop_cnt = drop_cnt_q;
`else
  assign wdrop_cnt = '0;
`endif

endmodule
